// File: rtl/shift_reg_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the
// shift_register_seq shift/rotate unit.
package shift_reg_pkg;

    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_SHR   = 3'd3;
    localparam logic [2:0] OP_SAR   = 3'd4;
    localparam logic [2:0] OP_ROL   = 3'd5;
    localparam logic [2:0] OP_ROR   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the op codes that move bits one position per cycle.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-position shifter/rotator; non-shift op codes pass the
// input value through unchanged.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_SHL:  data_o = {data_i[WIDTH-2:0], sin_i};
            OP_SHR:  data_o = {sin_i, data_i[WIDTH-1:1]};
            OP_SAR:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            OP_ROL:  data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            OP_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_register_seq.sv
// Multi-mode shift register that shifts one position per clock, with a
// start/busy/done handshake and iterative semantics for large amounts.
module shift_register_seq
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [2:0]       set,
    input  logic [MW-1:0]    M,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] outstate,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [MW-1:0]    count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic             sin_q, sin_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] step_val;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i   (op_q),
        .sin_i  (sin_q),
        .data_i (data_q),
        .data_o (step_val)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= OP_HOLD;
            sin_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            sin_q   <= sin_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        sin_d   = sin_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_op(set) && (M != '0)) begin
                        // Value is untouched on the accept edge; shifting starts next edge.
                        op_d    = set;
                        sin_d   = sin;
                        count_d = M;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                        case (set)
                            OP_LOAD:  data_d = D;
                            OP_CLEAR: data_d = '0;
                            default:  data_d = data_q;
                        endcase
                    end
                end
            end
            ST_SHIFT: begin
                data_d  = step_val;
                count_d = count_q - MW'(1);
                if (count_q == MW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign outstate = data_q;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_register_seq.sv
// Scoreboard bench for shift_register_seq: the stimulus side queues the
// expected final value and busy length per op; a monitor checks on done.
module tb_shift_register_seq;
    import shift_reg_pkg::*;

    localparam int WIDTH = 16;
    localparam int MW    = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             res;
    logic             start;
    logic [2:0]       set;
    logic [MW-1:0]    M;
    logic [WIDTH-1:0] D;
    logic             sin;
    logic [WIDTH-1:0] outstate;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               busy_cycles;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    busy_cnt = 0;

    shift_register_seq #(
        .WIDTH (WIDTH),
        .MW    (MW)
    ) dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .set      (set),
        .M        (M),
        .D        (D),
        .sin      (sin),
        .outstate (outstate),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: counts busy cycles and scores each done pulse against the queue.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done with outstate %h, expected no done", outstate);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_value"}, outstate, e.val);
                check({nm, "_busy_cycles"}, WIDTH'(busy_cnt), WIDTH'(e.busy_cycles));
            end
            busy_cnt = 0;
        end
        if (res === 1'b0) busy_cnt = 0;
    end

    task automatic expect_op(input string nm, input logic [WIDTH-1:0] v, input int b);
        exp_t e;
        e.val = v;
        e.busy_cycles = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Called one delta after a rising edge while the DUT is idle.
    task automatic issue(input logic [2:0] op, input logic [MW-1:0] m,
                         input logic [WIDTH-1:0] d, input logic s);
        start = 1'b1;
        set   = op;
        M     = m;
        D     = d;
        sin   = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", nm, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [MW-1:0] m,
                          input logic [WIDTH-1:0] d, input logic s,
                          input logic [WIDTH-1:0] v, input int b);
        expect_op(nm, v, b);
        issue(op, m, d, s);
        wait_done(nm);
    endtask

    initial begin
        res   = 1'b0;
        start = 1'b0;
        set   = OP_HOLD;
        M     = '0;
        D     = '0;
        sin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outstate", outstate, 16'h0000);
        check("reset_busy", WIDTH'(busy), 16'h0000);
        check("reset_done", WIDTH'(done), 16'h0000);
        res = 1'b1;

        run_op("load_0269", OP_LOAD, 0, 16'h0269, 1'b0, 16'h0269, 0);

        // SHL by 3 with every intermediate value checked.
        expect_op("shl3", 16'h1348, 3);
        issue(OP_SHL, 3, 16'h0000, 1'b0);
        check("shl3_accept_value", outstate, 16'h0269);
        check("shl3_accept_busy", WIDTH'(busy), 16'h0001);
        @(posedge clk); #1;
        check("shl3_step1", outstate, 16'h04D2);
        @(posedge clk); #1;
        check("shl3_step2", outstate, 16'h09A4);
        @(posedge clk); #1;
        check("shl3_step3", outstate, 16'h1348);
        check("shl3_done_high", WIDTH'(done), 16'h0001);
        @(posedge clk); #1;

        run_op("load_8269a", OP_LOAD, 0, 16'h8269, 1'b0, 16'h8269, 0);
        run_op("sar3",       OP_SAR,  3, 16'h0000, 1'b0, 16'hF04D, 3);
        run_op("load_8269b", OP_LOAD, 0, 16'h8269, 1'b0, 16'h8269, 0);
        run_op("shr3_sin1",  OP_SHR,  3, 16'h0000, 1'b1, 16'hF04D, 3);
        run_op("load_8269c", OP_LOAD, 0, 16'h8269, 1'b0, 16'h8269, 0);
        run_op("shr3_sin0",  OP_SHR,  3, 16'h0000, 1'b0, 16'h104D, 3);
        run_op("load_0269b", OP_LOAD, 0, 16'h0269, 1'b0, 16'h0269, 0);
        run_op("ror4",       OP_ROR,  4, 16'h0000, 1'b0, 16'h9026, 4);
        run_op("load_0269c", OP_LOAD, 0, 16'h0269, 1'b0, 16'h0269, 0);
        run_op("rol20",      OP_ROL, 20, 16'h0000, 1'b0, 16'h2690, 20);
        run_op("shl0",       OP_SHL,  0, 16'h0000, 1'b1, 16'h2690, 0);
        run_op("hold",       OP_HOLD, 0, 16'hFFFF, 1'b1, 16'h2690, 0);

        // start stays high through SHIFT and DONE with a different request.
        expect_op("shl2_start_held", 16'h9A40, 2);
        issue(OP_SHL, 2, 16'h0000, 1'b0);
        start = 1'b1;
        set   = OP_LOAD;
        M     = 7;
        D     = 16'hFFFF;
        sin   = 1'b1;
        begin
            int n;
            n = 0;
            while (done !== 1'b1 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL shl2_start_held_timeout: got no done, expected done");
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("start_held_ignored", outstate, 16'h9A40);
        @(posedge clk); #1;

        run_op("clear", OP_CLEAR, 0, 16'hFFFF, 1'b1, 16'h0000, 0);

        // Reset in the middle of a long shift: no done, then a fresh LOAD.
        run_op("load_0001", OP_LOAD, 0, 16'h0001, 1'b0, 16'h0001, 0);
        issue(OP_SHL, 10, 16'h0000, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", WIDTH'(busy), 16'h0001);
        check("abort_value_before", outstate, 16'h0010);
        res = 1'b0;
        @(posedge clk); #1;
        check("abort_outstate", outstate, 16'h0000);
        check("abort_busy", WIDTH'(busy), 16'h0000);
        check("abort_done", WIDTH'(done), 16'h0000);
        res = 1'b1;
        expect_op("load_after_reset", 16'h00A5, 0);
        issue(OP_LOAD, 0, 16'h00A5, 1'b0);
        check("load_after_reset_direct", outstate, 16'h00A5);
        wait_done("load_after_reset");

        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_register_seq.md
# shift_register_seq

Parametrised multi-mode shift register with a start/busy/done handshake. It is the successor to the fixed 16-bit mode register: width and shift-amount width are generic, it adds arithmetic shift, rotate, a serial fill bit and explicit completion signalling, and it shifts one position per clock so large shift amounts cost no extra logic depth. It sits in the datapath as the shift/rotate unit, driven by a controller that issues one operation at a time.

## Interface
- WIDTH, 16: data width in bits (≥2).
- MW, $clog2(WIDTH)+1: shift-amount width; amounts 0..2^MW−1 are legal.

- clk  in  1  clock; all logic on rising edge.
- res  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- set  in  3  operation code, sampled with start.
- M  in  MW  shift amount, sampled with start.
- D  in  WIDTH  load value, sampled with start.
- sin  in  1  fill bit for logical shifts, sampled with start.
- outstate  out  WIDTH  register contents.
- busy  out  1  high while shifting.
- done  out  1  one-cycle completion pulse.

## Operation
- Op codes:
  - 0 HOLD: no change.
  - 1 LOAD: outstate←D.
  - 2 SHL: shift left, fill sin at LSB.
  - 3 SHR: shift right, fill sin at MSB.
  - 4 SAR: shift right, MSB replicated.
  - 5 ROL: rotate left.
  - 6 ROR: rotate right.
  - 7 CLEAR: outstate←0.
- FSM states IDLE, SHIFT, DONE.
  - IDLE, start=1, op is HOLD/LOAD/CLEAR, or shift op with M=0: apply op at this edge, go to DONE.
  - IDLE, start=1, shift op with M>0: latch op, sin and count←M; go to SHIFT; outstate unchanged at this edge.
  - SHIFT: each edge shifts outstate one position and decrements count. The edge that applies the M-th shift goes to DONE.
  - DONE: go to IDLE unconditionally.
- busy = (state==SHIFT); done = (state==DONE); both are decoded from registered state, so they are glitch-free.
- start, set, M, D and sin are ignored outside IDLE, including a start presented during the DONE cycle.
- M ≥ WIDTH follows iterative semantics:
  - logical/arithmetic shifts saturate to all-fill (all-sign for SAR);
  - rotates act modulo WIDTH;
  - the shift still takes M cycles.
- Reset (res=0 at an edge):
  - outstate←0, state←IDLE, count←0, busy=0, done=0.
  - Reset overrides start.
  - Reset mid-shift aborts the operation with no done pulse.

## Timing
- Start accepted at edge k, single-cycle op: outstate valid after edge k; done high in cycle k→k+1; next start accepted at edge k+1 is not possible (state is DONE), so the earliest next start is at edge k+2.
- Shift with M>0 accepted at edge k:
  - Intermediate shifts at edges k+1..k+M, visible on outstate one per cycle.
  - busy high in cycles k→k+M.
  - done high in cycle k+M→k+M+1.
  - IDLE again after edge k+M+1.
- Throughput: one op per M+2 cycles for shifts; one per 2 cycles for single-cycle ops.
- No combinational path from any input to any output.

## Structure
- Package shift_reg_pkg holds:
  - op-code localparams OP_HOLD…OP_CLEAR;
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step is the combinational one-position shifter (WIDTH, op, sin in; next value out).
- The top level holds the FSM, count register, latched op/sin, and outstate register.

## Test plan
- Reset, then LOAD D=16'h0269:
  - outstate=16'h0269 after the accept edge;
  - done pulses one cycle; busy never rises.
- From 16'h0269, SHL M=3 sin=0:
  - outstate goes 16'h04D2, 16'h09A4, then 16'h1348 on successive edges;
  - busy high 3 cycles, then done for 1 cycle.
- LOAD 16'h8269, then SAR M=3 → 16'hF04D. Repeat with SHR M=3 sin=1 → 16'hF04D; with sin=0 → 16'h104D.
- From 16'h0269:
  - ROR M=4 → 16'h9026;
  - reload, then ROL M=20 → 16'h2690, with busy high for exactly 20 cycles.
- Corner cases:
  - shift with M=0 leaves the value unchanged, with done on the next cycle and busy never high;
  - start held high throughout SHIFT and DONE is ignored;
  - CLEAR → 16'h0000.
- Assert res=0 mid-way through a SHL M=10:
  - next cycle outstate=0, busy=0;
  - no done pulse;
  - a fresh LOAD is accepted the cycle after res returns high.
